// File: rtl/rtype_multi_cycle.sv
// Multi-cycle RV32/RV64 R-type core: FETCH -> DECODE -> EXEC -> WB, four cycles per instruction.
// Any non-R-type or unsupported encoding parks the core in HALT until reset.
module rtype_multi_cycle #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int PC_W  = 8
) (
  input  logic            clock,
  input  logic            reset,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instruction,
  output logic [XLEN-1:0] ALU_result,
  output logic            zero,
  output logic [2:0]      state,
  output logic            retired,
  output logic [31:0]     retire_count,
  output logic            halted
);

  localparam int SHW = $clog2(XLEN);
  localparam int RIDX_W = $clog2(NREGS);
  localparam logic [5:0] NREGS_L = 6'(NREGS);
  localparam logic [6:0] OPC_RTYPE = 7'b0110011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
    OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND, OP_ILLEGAL
  } alu_op_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [PC_W-1:0]   r_pc;
  logic [31:0]       r_ir;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_alu;
  logic              r_zero;
  logic [31:0]       r_retire_count;
  logic [XLEN-1:0]   r_regs [NREGS];

  logic [6:0]        w_opcode;
  logic [4:0]        w_rd;
  logic [4:0]        w_rs1;
  logic [4:0]        w_rs2;
  logic [2:0]        w_funct3;
  logic [6:0]        w_funct7;
  logic [RIDX_W-1:0] w_rd_idx;
  logic [RIDX_W-1:0] w_rs1_idx;
  logic [RIDX_W-1:0] w_rs2_idx;
  logic              w_idx_ok;
  logic              w_legal;
  alu_op_t           w_alu_op;
  logic [SHW-1:0]    w_shamt;
  logic [XLEN-1:0]   w_alu;
  logic [XLEN-1:0]   w_rs1_val;
  logic [XLEN-1:0]   w_rs2_val;

  // IR stays stable from DECODE through WB, so all fields decode straight from it.
  assign w_opcode  = r_ir[6:0];
  assign w_rd      = r_ir[11:7];
  assign w_funct3  = r_ir[14:12];
  assign w_rs1     = r_ir[19:15];
  assign w_rs2     = r_ir[24:20];
  assign w_funct7  = r_ir[31:25];
  assign w_rd_idx  = w_rd[RIDX_W-1:0];
  assign w_rs1_idx = w_rs1[RIDX_W-1:0];
  assign w_rs2_idx = w_rs2[RIDX_W-1:0];
  assign w_shamt   = r_b[SHW-1:0];

  assign w_idx_ok  = ({1'b0, w_rs1} < NREGS_L) && ({1'b0, w_rs2} < NREGS_L) &&
                     ({1'b0, w_rd} < NREGS_L);
  assign w_legal   = (w_opcode == OPC_RTYPE) && (w_alu_op != OP_ILLEGAL) && w_idx_ok;

  assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1_idx];
  assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2_idx];

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_alu_op = OP_ILLEGAL;
    case ({w_funct7, w_funct3})
      {7'h00, 3'b000}: w_alu_op = OP_ADD;
      {7'h20, 3'b000}: w_alu_op = OP_SUB;
      {7'h00, 3'b001}: w_alu_op = OP_SLL;
      {7'h00, 3'b010}: w_alu_op = OP_SLT;
      {7'h00, 3'b011}: w_alu_op = OP_SLTU;
      {7'h00, 3'b100}: w_alu_op = OP_XOR;
      {7'h00, 3'b101}: w_alu_op = OP_SRL;
      {7'h20, 3'b101}: w_alu_op = OP_SRA;
      {7'h00, 3'b110}: w_alu_op = OP_OR;
      {7'h00, 3'b111}: w_alu_op = OP_AND;
      default:         w_alu_op = OP_ILLEGAL;
    endcase
  end

  always_comb begin
    w_alu = '0;
    case (w_alu_op)
      OP_ADD:  w_alu = r_a + r_b;
      OP_SUB:  w_alu = r_a - r_b;
      OP_SLL:  w_alu = r_a << w_shamt;
      OP_SLT:  w_alu = XLEN'($signed(r_a) < $signed(r_b));
      OP_SLTU: w_alu = XLEN'(r_a < r_b);
      OP_XOR:  w_alu = r_a ^ r_b;
      OP_SRL:  w_alu = r_a >> w_shamt;
      OP_SRA:  w_alu = $signed(r_a) >>> w_shamt;
      OP_OR:   w_alu = r_a | r_b;
      OP_AND:  w_alu = r_a & r_b;
      default: w_alu = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:  w_next_state = S_DECODE;
      S_DECODE: w_next_state = w_legal ? S_EXEC : S_HALT;
      S_EXEC:   w_next_state = S_WB;
      S_WB:     w_next_state = S_FETCH;
      S_HALT:   w_next_state = S_HALT;
      default:  w_next_state = S_FETCH;
    endcase
  end

  always_comb begin
    retired = (r_state == S_WB);
    halted  = (r_state == S_HALT);
    state   = r_state;
  end

  // NOTE: the register file is reset deliberately -- x[i] must power up holding i -- so it cannot map to a reset-less RAM.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc           <= '0;
      r_ir           <= '0;
      r_a            <= '0;
      r_b            <= '0;
      r_alu          <= '0;
      r_zero         <= 1'b0;
      r_retire_count <= '0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= XLEN'(i);
    end else begin
      case (r_state)
        S_FETCH:  r_ir <= imem_rdata;
        S_DECODE: begin
          r_a <= w_rs1_val;
          r_b <= w_rs2_val;
        end
        S_EXEC: begin
          r_alu  <= w_alu;
          r_zero <= (w_alu == '0);
        end
        S_WB: begin
          if (w_rd != 5'd0) r_regs[w_rd_idx] <= r_alu;
          r_pc           <= r_pc + PC_W'(4);
          r_retire_count <= r_retire_count + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr    = r_pc;
  assign instruction  = r_ir;
  assign ALU_result   = r_alu;
  assign zero         = r_zero;
  assign retire_count = r_retire_count;

endmodule

// File: tb/tb_rtype_multi_cycle.sv
// Scoreboard bench for rtype_multi_cycle: directed programs push expected retirements,
// an independent monitor pops and compares on every retired pulse.
module tb_rtype_multi_cycle;

  logic        clock;
  logic        reset;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] ALU_result;
  logic        zero;
  logic [2:0]  state;
  logic        retired;
  logic [31:0] retire_count;
  logic        halted;

  rtype_multi_cycle #(.XLEN(32), .NREGS(32), .PC_W(8)) dut (
    .clock(clock), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instruction(instruction), .ALU_result(ALU_result), .zero(zero), .state(state),
    .retired(retired), .retire_count(retire_count), .halted(halted)
  );

  typedef struct {
    logic [31:0] alu;
    logic        z;
    logic [7:0]  pc;
    logic [31:0] cnt;
  } exp_t;

  logic [31:0] imem [64];
  exp_t        sb [$];
  int          total = 0;
  int          bad   = 0;

  assign imem_rdata = imem[imem_addr[7:2]];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  task automatic push(input int idx, input logic [31:0] ins, input logic [31:0] val);
    exp_t e;
    imem[idx] = ins;
    e.alu = val;
    e.z   = (val == 32'd0);
    e.pc  = 8'(idx * 4);
    e.cnt = 32'(idx);
    sb.push_back(e);
  endtask

  task automatic wait_count(input logic [31:0] n, input int budget, input string nm);
    for (int i = 0; i < budget && retire_count !== n; i++) @(negedge clock);
    check(nm, retire_count, n);
  endtask

  task automatic wait_halt(input int budget, input string nm);
    for (int i = 0; i < budget && halted !== 1'b1; i++) @(negedge clock);
    check(nm, halted, 1'b1);
  endtask

  // Monitor: every retired pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && retired === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_retire", retire_count, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("alu[%0d]", e.cnt), ALU_result, e.alu);
        check($sformatf("zero[%0d]", e.cnt), zero, e.z);
        check($sformatf("pc[%0d]", e.cnt), imem_addr, e.pc);
        check($sformatf("count[%0d]", e.cnt), retire_count, e.cnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic any_ret;
    reset = 1'b1;
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;

    // Program 1: directed R-type vectors, then filler to wrap the PC.
    push(0,  32'h006283B3,                  32'd11);
    push(1,  32'h40528433,                  32'd0);
    push(2,  enc(7'h00, 5'd6, 5'd5, 3'd0, 5'd0),  32'd11);
    push(3,  enc(7'h00, 5'd0, 5'd0, 3'd0, 5'd11), 32'd0);
    push(4,  enc(7'h20, 5'd5, 5'd0, 3'd0, 5'd9),  32'hFFFF_FFFB);
    push(5,  enc(7'h20, 5'd1, 5'd9, 3'd5, 5'd10), 32'hFFFF_FFFD);
    push(6,  enc(7'h00, 5'd0, 5'd7, 3'd0, 5'd12), 32'd11);
    push(7,  enc(7'h00, 5'd10, 5'd8, 3'd0, 5'd13), 32'hFFFF_FFFD);
    push(8,  enc(7'h00, 5'd2, 5'd3, 3'd1, 5'd14), 32'd12);
    push(9,  enc(7'h00, 5'd1, 5'd9, 3'd2, 5'd15), 32'd1);
    push(10, enc(7'h00, 5'd1, 5'd9, 3'd3, 5'd16), 32'd0);
    push(11, enc(7'h00, 5'd6, 5'd5, 3'd4, 5'd17), 32'd3);
    push(12, enc(7'h00, 5'd4, 5'd9, 3'd5, 5'd18), 32'h0FFF_FFFF);
    push(13, enc(7'h00, 5'd2, 5'd5, 3'd6, 5'd19), 32'd7);
    push(14, enc(7'h00, 5'd6, 5'd5, 3'd7, 5'd20), 32'd4);
    push(15, enc(7'h00, 5'd9, 5'd1, 3'd1, 5'd21), 32'h0800_0000);
    for (int k = 0; k < 48; k++)
      push(16 + k, enc(7'h00, 5'd1, 5'd23, 3'd0, 5'd23), 32'(24 + k));

    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("rst_state", state, 3'd0);
    check("rst_pc", imem_addr, 8'h00);
    check("rst_alu", ALU_result, 32'd0);
    check("rst_zero", zero, 1'b0);
    check("rst_count", retire_count, 32'd0);
    check("rst_ir", instruction, 32'd0);
    check("rst_halted", halted, 1'b0);
    check("rst_retired", retired, 1'b0);

    wait_count(32'd64, 400, "wrap_count");
    check("wrap_pc", imem_addr, 8'h00);
    check("wrap_state", state, 3'd0);
    check("sb_empty_1", sb.size(), 0);

    // Program 2: one add overwriting x5, then a non-R-type word halts the core.
    reset = 1'b1;
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    push(0, enc(7'h00, 5'd6, 5'd5, 3'd0, 5'd5), 32'd11);
    imem[1] = 32'h0000_0013;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    wait_halt(40, "halt_entered");
    check("halt_state", state, 3'd4);
    check("halt_pc", imem_addr, 8'h04);
    check("halt_count", retire_count, 32'd1);
    check("halt_alu", ALU_result, 32'd11);
    check("halt_ir", instruction, 32'h0000_0013);
    any_ret = 1'b0;
    repeat (8) begin
      @(negedge clock);
      any_ret = any_ret | retired;
    end
    check("halt_no_retire", any_ret, 1'b0);
    check("halt_pc_frozen", imem_addr, 8'h04);
    check("halt_state_held", state, 3'd4);

    // Program 3: single-cycle reset out of HALT restores x5 = 5.
    reset = 1'b1;
    push(0, enc(7'h00, 5'd0, 5'd5, 3'd0, 5'd12), 32'd5);
    push(1, enc(7'h20, 5'd6, 5'd5, 3'd0, 5'd13), 32'hFFFF_FFFF);
    imem[2] = 32'h0000_0013;
    @(negedge clock);
    reset = 1'b0;
    check("rst2_state", state, 3'd0);
    check("rst2_pc", imem_addr, 8'h00);
    check("rst2_halted", halted, 1'b0);
    check("rst2_alu", ALU_result, 32'd0);
    wait_halt(60, "halt2_entered");
    check("halt2_count", retire_count, 32'd2);
    check("sb_empty_2", sb.size(), 0);

    // Program 4: reset during EXEC aborts the instruction before writeback.
    reset = 1'b1;
    imem[0] = enc(7'h00, 5'd6, 5'd6, 3'd0, 5'd5);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 10 && state !== 3'd2; i++) @(negedge clock);
    check("reach_exec", state, 3'd2);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_state", state, 3'd0);
    check("abort_count", retire_count, 32'd0);
    check("abort_alu", ALU_result, 32'd0);
    check("abort_retired", retired, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rtype_multi_cycle.md
RTYPE_MULTI_CYCLE -- requirements
Module: rtype_multi_cycle

Interface
REQ-001 Parameter XLEN, default 32, datapath and register width; legal values are 32 and 64.
REQ-002 Parameter NREGS, default 32, architectural register count; legal values are 16 and 32.
REQ-003 Parameter PC_W, default 8, byte-address width of the program counter and instruction port.
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset; sampled on the rising edge of clock.
REQ-006 imem_addr  output  PC_W  byte address of the instruction being fetched; always equals PC.
REQ-007 imem_rdata  input  32  instruction word from combinational instruction memory at imem_addr.
REQ-008 instruction  output  32  instruction register (IR) contents.
REQ-009 ALU_result  output  XLEN  registered ALU output of the most recently executed instruction.
REQ-010 zero  output  1  registered flag, 1 when the latched ALU_result is 0.
REQ-011 state  output  3  current FSM state encoding: FETCH=0, DECODE=1, EXEC=2, WB=3, HALT=4.
REQ-012 retired  output  1  one-cycle pulse in the WB cycle of each completed instruction.
REQ-013 retire_count  output  32  count of retired instructions; wraps modulo 2^32.
REQ-014 halted  output  1  high while state is HALT.

Function
REQ-015 The FSM SHALL sequence FETCH -> DECODE -> EXEC -> WB -> FETCH, taking 4 cycles per instruction.
REQ-016 FETCH: latch imem_rdata into IR.
REQ-017 DECODE: read rs1 (IR[19:15]) and rs2 (IR[24:20]) into operand registers A and B; register x0 always reads 0.
REQ-018 DECODE: go to HALT instead of EXEC if opcode IR[6:0] != 7'b0110011.
REQ-019 DECODE: go to HALT if rs1, rs2 or rd (IR[11:7]) >= NREGS.
REQ-020 DECODE: go to HALT on any funct7/funct3 pair not listed in REQ-021.
REQ-021 EXEC: compute from funct7/funct3 (funct7 0x00 unless noted): ADD(000), SUB(000, funct7 0x20), SLL(001), SLT(010, signed), SLTU(011), XOR(100), SRL(101), SRA(101, funct7 0x20), OR(110), AND(111).
REQ-022 EXEC: latch the result into ALU_result and set zero = (result == 0).
REQ-023 Shift amount SHALL be B[$clog2(XLEN)-1:0]; arithmetic wraps modulo 2^XLEN; SLT/SLTU yield 1 or 0 zero-extended.
REQ-024 WB: write ALU_result to rd unless rd == 0; pulse retired; increment retire_count.
REQ-025 WB: PC <= PC + 4, wrapping modulo 2^PC_W.
REQ-026 In HALT: state is held, PC is frozen, no register writes occur, retired stays 0; only reset exits HALT.
REQ-027 Register writes occur only in WB; ALU_result and zero change only in EXEC.
REQ-028 No write-to-read bypass is needed, since WB always precedes the next DECODE.

Reset
REQ-029 On reset: state=FETCH, PC=0, IR=0, ALU_result=0, zero=0, retired=0, retire_count=0, halted=0.
REQ-030 On reset: register x[i] SHALL be loaded with value i, zero-extended to XLEN, for all i < NREGS (x0=0).
REQ-031 Reset asserted in any state, including mid-EXEC or HALT, SHALL take effect on that edge; an in-flight instruction does not write back.

Verification
REQ-032 Reset released -> state=0, imem_addr=0x00, ALU_result=0, zero=0, retire_count=0.
REQ-033 imem[0]=0x006283B3 (add x7,x5,x6) -> after 4 cycles: ALU_result=11, zero=0, x7=11, one retired pulse, imem_addr=0x04, retire_count=1.
REQ-034 0x40528433 (sub x8,x5,x5) -> ALU_result=0, zero=1, x8=0.
REQ-035 add x0,x5,x6 -> ALU_result=11 but x0 still reads 0 in a following add x11,x0,x0 (ALU_result=0).
REQ-036 Run sub x9,x0,x5 then sra x10,x9,x1 -> x9=0xFFFFFFFB; x10=0xFFFFFFFD (XLEN=32).
REQ-037 0x00000013 (addi) -> HALT entered from DECODE, halted=1, PC frozen, no retired pulse.
REQ-038 From REQ-037, reset asserted for 1 cycle -> FETCH, PC=0, x5=5.
REQ-039 Run 64 instructions with PC_W=8 -> PC wraps 0xFC -> 0x00 and retire_count=64.
